// File: rtl/burst_serializer.sv
// burst_serializer: valid/ready words to framed LSB-first serial bursts; define BURST_PARITY_EN for a per-word even-parity bit
module burst_serializer #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              ser_data,
  output logic              ser_active,
  output logic              burst_done,
  output logic              err_underrun,
  output logic [7:0]        word_count
);
  localparam int IW = $clog2(DATA_W);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, SHIFT = 3'd2, GAP = 3'd3;
`ifdef BURST_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif
  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              abort_q, abort_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_active_q, ser_active_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              fin, par_bit;
`ifdef BURST_PARITY_EN
  assign fin     = state_q == PARITY;
  assign par_bit = state_d == PARITY && ^word_d;
`else
  assign fin     = state_q == SHIFT && idx_q == IDX_LAST;
  assign par_bit = 1'b0;
`endif
  assign s_ready = !reset && (state_q == IDLE || (fin && !last_q));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    last_d  = last_q;
    gap_d   = gap_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (s_valid) begin
        state_d = START;
        word_d  = s_data;
        last_d  = s_last;
        cnt_d   = 8'd1;
        abort_d = 1'b0;
      end
      START: begin
        state_d = SHIFT;
        idx_d   = '0;
      end
      SHIFT: begin
        idx_d = idx_q + 1'b1;
`ifdef BURST_PARITY_EN
        state_d = idx_q == IDX_LAST ? PARITY : SHIFT;
`endif
      end
      GAP: begin
        state_d = gap_q == GAP_LAST ? IDLE : GAP;
        gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // word boundary: close the burst, chain the next word, or abort on underrun
    if (fin) begin
      if (!last_q && s_valid) begin
        state_d = SHIFT;
        idx_d   = '0;
        word_d  = s_data;
        last_d  = s_last;
        cnt_d   = cnt_q + {7'd0, cnt_q != 8'hFF};
      end else begin
        state_d = GAP;
        gap_d   = '0;
        abort_d = !last_q;
        err_d   = !last_q;
      end
    end
  end
  assign ser_data_d   = state_d == START || (state_d == SHIFT && word_d[idx_d]) || par_bit;
  assign ser_active_d = state_d != IDLE && state_d != GAP;
  assign done_d       = state_d == GAP && gap_d == GAP_LAST && !abort_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
      gap_q        <= '0;
      abort_q      <= 1'b0;
      cnt_q        <= 8'd0;
      ser_data_q   <= 1'b0;
      ser_active_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      last_q       <= last_d;
      gap_q        <= gap_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
      ser_data_q   <= ser_data_d;
      ser_active_q <= ser_active_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end
  assign ser_data     = ser_data_q;
  assign ser_active   = ser_active_q;
  assign burst_done   = done_q;
  assign err_underrun = err_q;
  assign word_count   = cnt_q;
endmodule

// File: tb/tb_burst_serializer.sv
// tb_burst_serializer: directed checks of framing, chaining, underrun, reset abort and count saturation
module tb_burst_serializer;
  localparam int DW = 8;
  localparam int GC = 2;
`ifdef BURST_PARITY_EN
  localparam int PER = DW + 1;
`else
  localparam int PER = DW;
`endif
  logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, ser_data, ser_active, burst_done, err_underrun;
  logic [7:0] word_count;
  int total = 0, bad = 0, dones = 0, errs = 0;
  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vt [7];
  logic [7:0] bw [3];
  logic       bp [3];
  burst_serializer #(.DATA_W(DW), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .ser_data(ser_data), .ser_active(ser_active),
    .burst_done(burst_done), .err_underrun(err_underrun), .word_count(word_count)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    dones += burst_done ? 1 : 0;
    errs  += err_underrun ? 1 : 0;
  endtask
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int k);
    if (k < DW) return d[3'(k)];
    return p;
  endfunction
  task automatic single(input logic [7:0] d, input logic par);
    int d0;
    chk("idle_ready", s_ready, 1);
    s_valid = 1'b1; s_data = d; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    d0 = dones;
    for (int c = 1; c <= 1 + PER + GC; c++) begin
      chk($sformatf("single_data_%0h_c%0d", d, c), ser_data,
          c == 1 ? 1 : (c <= 1 + PER ? 32'(exp_bit(d, par, c - 2)) : 0));
      chk($sformatf("single_active_c%0d", c), ser_active, 32'(c <= 1 + PER));
      chk($sformatf("single_done_c%0d", c), burst_done, 32'(c == 1 + PER + GC));
      chk($sformatf("single_ready_c%0d", c), s_ready, 0);
      chk($sformatf("single_err_c%0d", c), err_underrun, 0);
      tick();
    end
    chk("single_done_count", dones - d0, 1);
    chk("single_word_count", word_count, 1);
    chk("single_ready_after", s_ready, 1);
    chk("single_idle_data", ser_data, 0);
  endtask
  task automatic b2b();
    int d0, w;
    d0 = dones;
    s_valid = 1'b1; s_data = bw[0]; s_last = 1'b0;
    tick();
    s_data = bw[1];
    for (int c = 1; c <= 1 + 3 * PER + GC; c++) begin
      w = (c - 2) / PER;
      chk($sformatf("b2b_data_c%0d", c), ser_data,
          c == 1 ? 1 : (c <= 1 + 3 * PER ? 32'(exp_bit(bw[w], bp[w], (c - 2) % PER)) : 0));
      chk($sformatf("b2b_active_c%0d", c), ser_active, 32'(c <= 1 + 3 * PER));
      chk($sformatf("b2b_ready_c%0d", c), s_ready, 32'(c == 1 + PER || c == 1 + 2 * PER));
      chk($sformatf("b2b_done_c%0d", c), burst_done, 32'(c == 3 * PER + 3));
      if (c == 2 + PER) chk("b2b_mid_count", word_count, 2);
      tick();
      if (c == 1 + PER) begin
        s_data = bw[2]; s_last = 1'b1;
      end
      if (c == 1 + 2 * PER) begin
        s_valid = 1'b0; s_last = 1'b0;
      end
    end
    chk("b2b_word_count", word_count, 3);
    chk("b2b_done_count", dones - d0, 1);
  endtask
  task automatic underrun();
    int d0, e0;
    d0 = dones; e0 = errs;
    s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0;
    tick();
    s_valid = 1'b0;
    for (int c = 1; c <= 1 + PER + GC; c++) begin
      chk($sformatf("ur_data_c%0d", c), ser_data,
          c == 1 ? 1 : (c <= 1 + PER ? 32'(exp_bit(8'h3C, 1'b0, c - 2)) : 0));
      chk($sformatf("ur_active_c%0d", c), ser_active, 32'(c <= 1 + PER));
      chk($sformatf("ur_ready_c%0d", c), s_ready, 32'(c == 1 + PER));
      chk($sformatf("ur_err_c%0d", c), err_underrun, 32'(c == 2 + PER));
      chk($sformatf("ur_done_c%0d", c), burst_done, 0);
      tick();
    end
    chk("ur_err_count", errs - e0, 1);
    chk("ur_done_count", dones - d0, 0);
    chk("ur_ready_after", s_ready, 1);
    chk("ur_word_count", word_count, 1);
  endtask
  task automatic reset_mid();
    int d0, e0;
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    repeat (5) tick();
    chk("rst_bit4_data", ser_data, 0);
    chk("rst_bit4_active", ser_active, 1);
    chk("rst_bit4_count", word_count, 1);
    reset = 1'b1;
    #1;
    chk("rst_ready_low", s_ready, 0);
    d0 = dones; e0 = errs;
    tick();
    chk("rst_data", ser_data, 0);
    chk("rst_active", ser_active, 0);
    chk("rst_count", word_count, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_err", err_underrun, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", s_ready, 1);
    repeat (4) tick();
    chk("rst_no_done", dones - d0, 0);
    chk("rst_no_err", errs - e0, 0);
    chk("rst_idle_active", ser_active, 0);
  endtask
  task automatic saturate();
    int n, e0;
    logic hs, seen;
    n = 0; e0 = errs; seen = 1'b0;
    s_valid = 1'b1; s_data = 8'h00; s_last = 1'b0;
    for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
      hs = s_valid && s_ready;
      tick();
      if (burst_done) seen = 1'b1;
      if (hs) begin
        n++;
        if (n == 255) chk("sat_count_255", word_count, 255);
        if (n == 256) s_valid = 1'b0;
        else begin
          s_data = 8'(n);
          s_last = n == 255;
        end
      end
    end
    s_last = 1'b0;
    chk("sat_words", n, 256);
    chk("sat_done_seen", seen, 1);
    chk("sat_word_count", word_count, 255);
    chk("sat_no_err", errs - e0, 0);
  endtask
  initial begin
    vt[0] = '{8'hA5, 1'b0};
    vt[1] = '{8'h07, 1'b1};
    vt[2] = '{8'h03, 1'b0};
    vt[3] = '{8'h00, 1'b0};
    vt[4] = '{8'hFF, 1'b0};
    vt[5] = '{8'h80, 1'b1};
    vt[6] = '{8'h01, 1'b1};
    bw[0] = 8'h01; bw[1] = 8'h80; bw[2] = 8'hFF;
    bp[0] = 1'b1;  bp[1] = 1'b1;  bp[2] = 1'b0;
    tick();
    tick();
    chk("reset_data", ser_data, 0);
    chk("reset_active", ser_active, 0);
    chk("reset_done", burst_done, 0);
    chk("reset_err", err_underrun, 0);
    chk("reset_ready", s_ready, 0);
    chk("reset_count", word_count, 0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", s_ready, 1);
    tick();
    for (int i = 0; i < 7; i++) single(vt[i].data, vt[i].par);
    b2b();
    underrun();
    reset_mid();
    saturate();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
